alu_add_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle 16-bit adder in the ALU. Performs signed add, subtract, lane-wise (paddsb-style) add and lane reduction on WIDTH-bit operands, with optional saturation, a valid/ready handshake on both sides and a configurable number of register stages. Sits between the execute-stage operand muxes and the writeback/flag logic; backpressure from downstream stalls the whole unit.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_add_pipe_if.sv | 37 +++
 rtl/alu_add_core.sv | 138 +++++++++++++
 rtl/alu_add_pipe.sv | 98 +++++++++
 tb/tb_alu_add_pipe.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types for the pipelined ALU adder (alu_add_pipe).
//   - mode_e      : operation select carried on the operand bus
//   - alu_flags_t : flag part of a pipeline-stage payload (cout/ovf/zero)
//   - lane_count  : number of LANE_W lanes in a WIDTH-bit operand
//   The full stage payload pairs a WIDTH-bit sum with alu_flags_t. WIDTH is
//   a module parameter, so the payload struct itself is declared in the
//   module that owns the stage registers. The flag layout defined here keeps
//   that struct consistent.
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    PADD = 2'b10,
    RED  = 2'b11
  } mode_e;

  typedef struct packed {
    logic cout;  // carry out of the MSB (ADD/SUB only)
    logic ovf;   // signed overflow, detected before saturation
    logic zero;  // final (post-saturation) sum is zero
  } alu_flags_t;

  function automatic int lane_count(input int width, input int lane_w);
    return width / lane_w;
  endfunction

endpackage

// File: rtl/alu_add_pipe_if.sv
// ---------------------------------------------------------------------------
// alu_add_pipe_if
//   Operand/result bus of the pipelined ALU adder.
//   Upstream side : in_valid, in_ready, a, b, mode
//   Downstream    : out_valid, out_ready, sum, cout, ovf, zero
//   modport slave  - the adder unit
//   modport master - the surrounding execute/writeback logic
// ---------------------------------------------------------------------------
interface alu_add_pipe_if #(
  parameter int WIDTH = 16
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  mode_e            mode;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/alu_add_core.sv
// ---------------------------------------------------------------------------
// alu_add_core
//   Purely combinational datapath of the pipelined ALU adder.
//   Ports:
//     a, b   in  WIDTH  signed operands
//     mode   in  mode_e ADD / SUB / PADD / RED
//     sum    out WIDTH  final result (saturated when SAT != 0)
//     flags  out        cout / ovf / zero for this result
//   ADD/SUB share one adder (SUB = a + ~b + 1). PADD adds LANE_W lanes with
//   no inter-lane carry. RED sums all lanes of a and b through a balanced
//   adder tree; the leaf count is padded to a power of two with zeros.
// ---------------------------------------------------------------------------
module alu_add_core
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4,
  parameter int SAT    = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  mode_e            mode,
  output logic [WIDTH-1:0] sum,
  output alu_flags_t       flags
);

  localparam int NL    = lane_count(WIDTH, LANE_W);
  localparam int NLEAF = 2 * NL;
  localparam int LV    = $clog2(NLEAF);
  localparam int NP    = 1 << LV;

  localparam logic [WIDTH-1:0]  SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE_W-1:0] LMAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LMIN = {1'b1, {(LANE_W-1){1'b0}}};

  // ---------------------------------------------------------------------
  // ADD / SUB: one WIDTH+1 bit adder; the extra bit is the carry out.
  // ---------------------------------------------------------------------
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   as_full;
  logic [WIDTH-1:0] as_raw;
  logic             as_cout;
  logic             as_ovf;

  assign is_sub  = (mode == SUB);
  assign b_eff   = is_sub ? ~b : b;
  assign as_full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign as_raw  = as_full[WIDTH-1:0];
  assign as_cout = as_full[WIDTH];
  // Overflow when both addends share a sign and the result's sign differs.
  // Using b_eff makes the same test valid for SUB.
  assign as_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (as_raw[WIDTH-1] != a[WIDTH-1]);

  // ---------------------------------------------------------------------
  // PADD: independent LANE_W lanes, each saturating on its own overflow.
  // ---------------------------------------------------------------------
  logic [NL-1:0]    lane_ovf;
  logic [WIDTH-1:0] padd_sum;

  genvar gi;
  genvar gl;

  for (gi = 0; gi < NL; gi++) begin : g_lane
    logic [LANE_W-1:0] la;
    logic [LANE_W-1:0] lb;
    logic [LANE_W-1:0] ls;

    assign la = a[gi*LANE_W +: LANE_W];
    assign lb = b[gi*LANE_W +: LANE_W];
    assign ls = la + lb;
    assign lane_ovf[gi] = (la[LANE_W-1] == lb[LANE_W-1]) &&
                          (ls[LANE_W-1] != la[LANE_W-1]);
    assign padd_sum[gi*LANE_W +: LANE_W] =
      ((SAT != 0) && lane_ovf[gi]) ? (la[LANE_W-1] ? LMIN : LMAX) : ls;
  end

  // ---------------------------------------------------------------------
  // RED: balanced adder tree over all lanes of a (leaves 0..NL-1) and b
  // (leaves NL..2*NL-1), each lane sign-extended to WIDTH. Every level is
  // its own signal so the tree never reads the vector it drives. The sum
  // of 2*WIDTH/LANE_W lanes of LANE_W bits fits in WIDTH for legal params.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] red_sum;

  for (gl = 0; gl <= LV; gl++) begin : g_lvl
    logic [(NP >> gl)-1:0][WIDTH-1:0] node;

    for (gi = 0; gi < (NP >> gl); gi++) begin : g_node
      if (gl == 0) begin : g_leaf
        if (gi < NL) begin : g_a
          assign node[gi] = {{(WIDTH-LANE_W){a[gi*LANE_W+LANE_W-1]}},
                             a[gi*LANE_W +: LANE_W]};
        end else if (gi < NLEAF) begin : g_b
          assign node[gi] = {{(WIDTH-LANE_W){b[(gi-NL)*LANE_W+LANE_W-1]}},
                             b[(gi-NL)*LANE_W +: LANE_W]};
        end else begin : g_pad
          assign node[gi] = '0;
        end
      end else begin : g_add
        assign node[gi] = g_lvl[gl-1].node[2*gi] + g_lvl[gl-1].node[2*gi+1];
      end
    end
  end

  assign red_sum = g_lvl[LV].node[0];

  // ---------------------------------------------------------------------
  // Mode select and saturation. zero is taken from the final sum.
  // ---------------------------------------------------------------------
  always_comb begin
    sum   = '0;
    flags = '0;
    case (mode)
      ADD, SUB: begin
        flags.cout = as_cout;
        flags.ovf  = as_ovf;
        if ((SAT != 0) && as_ovf) begin
          // a's sign tells the direction of the overflow for both ADD and SUB
          sum = a[WIDTH-1] ? SMIN : SMAX;
        end else begin
          sum = as_raw;
        end
      end
      PADD: begin
        sum       = padd_sum;
        flags.ovf = |lane_ovf;
      end
      default: begin
        sum = red_sum;
      end
    endcase
    flags.zero = (sum == '0);
  end

endmodule

// File: rtl/alu_add_pipe.sv
// ---------------------------------------------------------------------------
// alu_add_pipe
//   Pipelined signed add / subtract / lane add / lane reduction unit.
//   Ports:
//     clk  in  clock, all state on the rising edge
//     rst  in  synchronous active-high reset, flushes every stage
//     bus  alu_add_pipe_if.slave
//            in_valid/in_ready/a/b/mode     operand beat (valid/ready)
//            out_valid/out_ready/sum/flags  result beat (valid/ready)
//   The result is computed combinationally from the accepted beat and then
//   carried through STAGES registers together with its flags. The whole
//   pipe moves as one: it shifts whenever the last stage is empty or is
//   being taken, and freezes otherwise. Bubbles are not collapsed, so a
//   beat accepted in cycle N is presented in cycle N+STAGES when unstalled.
// ---------------------------------------------------------------------------
module alu_add_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4,
  parameter int STAGES = 2,
  parameter int SAT    = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_add_pipe_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    alu_flags_t       flags;
  } stage_t;

  logic [WIDTH-1:0] core_sum;
  alu_flags_t       core_flags;
  stage_t           core_res;
  logic             advance;

  alu_add_core #(
    .WIDTH  (WIDTH),
    .LANE_W (LANE_W),
    .SAT    (SAT)
  ) u_core (
    .a     (bus.a),
    .b     (bus.b),
    .mode  (bus.mode),
    .sum   (core_sum),
    .flags (core_flags)
  );

  assign core_res.sum   = core_sum;
  assign core_res.flags = core_flags;

  // ---------------------------------------------------------------------
  // Stage registers. Stage 0 captures the core result; stage k captures
  // stage k-1. Data of an invalid stage is carried but never looked at.
  // ---------------------------------------------------------------------
  genvar gi;

  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic   valid_reg;
    stage_t data_reg;
    logic   valid_next;
    stage_t data_next;

    if (gi == 0) begin : g_head
      assign valid_next = bus.in_valid;
      assign data_next  = core_res;
    end else begin : g_body
      assign valid_next = g_stage[gi-1].valid_reg;
      assign data_next  = g_stage[gi-1].data_reg;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else if (advance) begin
        valid_reg <= valid_next;
        data_reg  <= data_next;
      end
    end
  end

  // Global advance: the last stage is empty or downstream takes it now.
  assign advance = !g_stage[STAGES-1].valid_reg || bus.out_ready;

  // A beat offered while reset is asserted is never accepted, so in_ready
  // is held low for that cycle to keep the handshake honest.
  assign bus.in_ready = advance && !rst;

  assign bus.out_valid = g_stage[STAGES-1].valid_reg;
  assign bus.sum       = g_stage[STAGES-1].data_reg.sum;
  assign bus.cout      = g_stage[STAGES-1].data_reg.flags.cout;
  assign bus.ovf       = g_stage[STAGES-1].data_reg.flags.ovf;
  assign bus.zero      = g_stage[STAGES-1].data_reg.flags.zero;

endmodule

// File: tb/tb_alu_add_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_add_pipe
//   Two instances share one stimulus stream: dut_sat (SAT=1) and dut_wrap
//   (SAT=0). Every accepted beat is pushed into a per-instance queue of
//   results computed by a reference model working on plain integers; every
//   presented result is compared with the queue head.
// ---------------------------------------------------------------------------
module tb_alu_add_pipe;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int L  = 4;
  localparam int NS = 2;
  localparam int NL = W / L;

  localparam int MAXS = (1 << (W-1)) - 1;
  localparam int MINS = -(1 << (W-1));
  localparam int LMAX = (1 << (L-1)) - 1;
  localparam int LMIN = -(1 << (L-1));

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_add_pipe_if #(.WIDTH(W)) bus1 ();
  alu_add_pipe_if #(.WIDTH(W)) bus0 ();

  alu_add_pipe #(.WIDTH(W), .LANE_W(L), .STAGES(NS), .SAT(1)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  alu_add_pipe #(.WIDTH(W), .LANE_W(L), .STAGES(NS), .SAT(0)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  assign bus0.in_valid  = bus1.in_valid;
  assign bus0.a         = bus1.a;
  assign bus0.b         = bus1.b;
  assign bus0.mode      = bus1.mode;
  assign bus0.out_ready = bus1.out_ready;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   out_cyc  = 0;
  int   n_out    = 0;
  bit   got_out;
  bit   in_fire;
  logic mon_in_ready;
  res_t last1;
  res_t last0;
  res_t q1[$];
  res_t q0[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lane_val(input logic [W-1:0] x, input int i);
    int v;
    v = int'(x[i*L +: L]);
    if (v > LMAX) v = v - (1 << L);
    return v;
  endfunction

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] m, input bit sat);
    res_t r;
    int   sa, sb, full, tot, ls;
    r  = '0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (m)
      2'b00, 2'b01: begin
        full   = (m == 2'b00) ? sa + sb : sa - sb;
        r.ovf  = (full > MAXS) || (full < MINS);
        r.cout = (m == 2'b00) ? ((int'(a) + int'(b)) >= (1 << W)) : (a >= b);
        if (sat && r.ovf) full = (full > 0) ? MAXS : MINS;
        r.sum  = full[W-1:0];
      end
      2'b10: begin
        for (int i = 0; i < NL; i++) begin
          ls = lane_val(a, i) + lane_val(b, i);
          if (ls > LMAX || ls < LMIN) begin
            r.ovf = 1'b1;
            if (sat) ls = (ls > 0) ? LMAX : LMIN;
          end
          r.sum[i*L +: L] = ls[L-1:0];
        end
      end
      default: begin
        tot = 0;
        for (int i = 0; i < NL; i++) tot = tot + lane_val(a, i) + lane_val(b, i);
        r.sum = tot[W-1:0];
      end
    endcase
    r.zero = (r.sum == '0);
    return r;
  endfunction

  // ---------------- one clock cycle with monitoring ----------------
  task automatic cycle();
    @(negedge clk);
    got_out      = 1'b0;
    in_fire      = 1'b0;
    mon_in_ready = bus1.in_ready;
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      if (bus1.out_valid) begin
        if (q1.size() == 0) begin
          chk("spurious_valid_sat", bus1.out_valid, 1'b0);
        end else begin
          chk("sum_sat", bus1.sum, q1[0].sum);
          chk("flags_sat", {bus1.cout, bus1.ovf, bus1.zero},
              {q1[0].cout, q1[0].ovf, q1[0].zero});
          if (bus1.out_ready) begin
            last1   = '{bus1.sum, bus1.cout, bus1.ovf, bus1.zero};
            void'(q1.pop_front());
            got_out = 1'b1;
            out_cyc = cyc;
            n_out++;
            $display("txn out cyc=%0d sum=0x%04h cout=%0b ovf=%0b zero=%0b",
                     cyc, bus1.sum, bus1.cout, bus1.ovf, bus1.zero);
          end
        end
      end
      if (bus0.out_valid) begin
        if (q0.size() == 0) begin
          chk("spurious_valid_wrap", bus0.out_valid, 1'b0);
        end else begin
          chk("sum_wrap", bus0.sum, q0[0].sum);
          chk("flags_wrap", {bus0.cout, bus0.ovf, bus0.zero},
              {q0[0].cout, q0[0].ovf, q0[0].zero});
          if (bus0.out_ready) begin
            last0 = '{bus0.sum, bus0.cout, bus0.ovf, bus0.zero};
            void'(q0.pop_front());
          end
        end
      end
      if (bus1.in_valid && bus1.in_ready) begin
        q1.push_back(model(bus1.a, bus1.b, bus1.mode, 1'b1));
        q0.push_back(model(bus1.a, bus1.b, bus1.mode, 1'b0));
        in_fire = 1'b1;
        acc_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue a single beat into an empty pipe and check the result constants.
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] m, input res_t e1,
                         input logic [W-1:0] e0_sum, input logic e0_ovf);
    bus1.a         = a;
    bus1.b         = b;
    bus1.mode      = mode_e'(m);
    bus1.in_valid  = 1'b1;
    bus1.out_ready = 1'b1;
    cycle();
    chk({tag, "_accept"}, 32'(in_fire), 32'd1);
    bus1.in_valid = 1'b0;
    for (int k = 0; k < 20 && !got_out; k++) cycle();
    chk({tag, "_seen"}, 32'(got_out), 32'd1);
    chk({tag, "_latency"}, out_cyc - acc_cyc, NS);
    chk({tag, "_sum"}, last1.sum, e1.sum);
    chk({tag, "_flags"}, {last1.cout, last1.ovf, last1.zero}, {e1.cout, e1.ovf, e1.zero});
    chk({tag, "_wrap_sum"}, last0.sum, e0_sum);
    chk({tag, "_wrap_ovf"}, last0.ovf, e0_ovf);
    $display("txn %s a=0x%04h b=0x%04h mode=%0d sum=0x%04h", tag, a, b, m, last1.sum);
  endtask

  logic [W-1:0] bp_a[4];
  logic [W-1:0] bp_b[4];
  logic [1:0]   bp_m[4];
  logic [W-1:0] corners[6];

  initial begin
    int idx;
    int start;

    corners = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h7777, 16'h8888};

    rst            = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.mode      = ADD;
    bus1.out_ready = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus1.out_valid, 1'b0);
    chk("rst_sum", bus1.sum, 16'h0000);
    chk("rst_flags", {bus1.cout, bus1.ovf, bus1.zero}, 3'b000);
    chk("rst_in_ready", bus1.in_ready, 1'b1);

    // ---------------- directed vectors ----------------
    run_one("add_pos_ovf", 16'h7000, 16'h2000, 2'b00, '{16'h7FFF, 1'b0, 1'b1, 1'b0}, 16'h9000, 1'b1);
    run_one("add_neg_ovf", 16'h8000, 16'hFFFF, 2'b00, '{16'h8000, 1'b1, 1'b1, 1'b0}, 16'h7FFF, 1'b1);
    run_one("add_zero",    16'h0001, 16'hFFFF, 2'b00, '{16'h0000, 1'b1, 1'b0, 1'b1}, 16'h0000, 1'b0);
    run_one("sub_borrow",  16'h0005, 16'h0007, 2'b01, '{16'hFFFE, 1'b0, 1'b0, 1'b0}, 16'hFFFE, 1'b0);
    run_one("sub_equal",   16'h1234, 16'h1234, 2'b01, '{16'h0000, 1'b1, 1'b0, 1'b1}, 16'h0000, 1'b0);
    run_one("sub_ovf",     16'h0000, 16'h8000, 2'b01, '{16'h7FFF, 1'b0, 1'b1, 1'b0}, 16'h8000, 1'b1);
    run_one("padd",        16'h718F, 16'h1111, 2'b10, '{16'h7290, 1'b0, 1'b1, 1'b0}, 16'h8290, 1'b1);
    run_one("red",         16'h1234, 16'h5678, 2'b11, '{16'h0014, 1'b0, 1'b0, 1'b0}, 16'h0014, 1'b0);

    // ---------------- backpressure: 4 beats, 3 stalled cycles ----------------
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 16'($urandom);
      bp_b[i] = 16'($urandom);
      bp_m[i] = 2'($urandom_range(0, 3));
    end
    idx   = 0;
    start = n_out;
    for (int c = 0; c < 30 && (n_out - start) < 4; c++) begin
      bus1.in_valid  = (idx < 4);
      bus1.a         = bp_a[idx % 4];
      bus1.b         = bp_b[idx % 4];
      bus1.mode      = mode_e'(bp_m[idx % 4]);
      bus1.out_ready = !(c >= 2 && c < 5);
      cycle();
      if (c >= 2 && c < 5) chk("bp_in_ready_stalled", mon_in_ready, 1'b0);
      if (in_fire) idx++;
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    chk("bp_accepted", idx, 4);
    chk("bp_delivered", n_out - start, 4);
    chk("bp_queue_empty", q1.size(), 0);
    $display("txn backpressure accepted=%0d delivered=%0d", idx, n_out - start);

    // ---------------- reset with beats in flight ----------------
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus1.in_valid = 1'b1;
      bus1.a        = 16'($urandom);
      bus1.b        = 16'($urandom);
      bus1.mode     = mode_e'($urandom_range(0, 3));
      cycle();
    end
    rst            = 1'b1;
    bus1.out_ready = 1'b0;
    bus1.a         = 16'h0101;
    cycle();
    rst           = 1'b0;
    bus1.in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus1.out_valid, 1'b0);
    chk("mid_rst_in_ready", bus1.in_ready, 1'b1);
    chk("mid_rst_sum", bus1.sum, 16'h0000);
    $display("txn mid-flight reset");
    run_one("post_rst", 16'h0003, 16'h0004, 2'b00, '{16'h0007, 1'b0, 1'b0, 1'b0}, 16'h0007, 1'b0);

    // ---------------- randomized stream ----------------
    for (int c = 0; c < 400; c++) begin
      bus1.in_valid  = ($urandom_range(0, 3) != 0);
      bus1.a         = ($urandom_range(0, 1) != 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      bus1.b         = ($urandom_range(0, 1) != 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      bus1.mode      = mode_e'($urandom_range(0, 3));
      bus1.out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    repeat (NS + 3) cycle();
    chk("drain_empty_sat", q1.size(), 0);
    chk("drain_empty_wrap", q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
